// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory read port, redirect input and the
// valid/ready instruction stream toward the decode/execute sequencer.
interface fetch_queue_if #(
   parameter int DEPTH = 4
);
   logic                      imem_rd_en;
   logic [7:0]                imem_addr;
   logic [7:0]                imem_data;
   logic                      redirect;
   logic [7:0]                redirect_pc;
   logic                      inst_valid;
   logic [7:0]                inst_data;
   logic [7:0]                inst_pc;
   logic                      inst_ready;
   logic [$clog2(DEPTH):0]    count;
   logic                      halted;

   modport master (
      output imem_rd_en, imem_addr, inst_valid, inst_data, inst_pc, count, halted,
      input  imem_data, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_rd_en, imem_addr, inst_valid, inst_data, inst_pc, count, halted,
      output imem_data, redirect, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential byte fetch, PC-tagged FIFO, redirect flush.
// Optional halt-word detection is enabled by defining FETCH_HALT_DETECT_EN.
//
// state | meaning
// RUN   | issuing sequential fetches while the queue has room
// HALT  | halt word (8'h00) captured; no issues until redirect or reset
module fetch_queue #(
   parameter int         DEPTH    = 4,
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic           clk,
   input  logic           reset,
   fetch_queue_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

`ifdef FETCH_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   typedef enum logic {RUN, HALT} state_t;

   state_t          state_q;
   logic [7:0]      fetch_pc_q;
   logic [7:0]      issued_pc_q;
   logic            inflight_q;
   logic            halted_q;
   logic [CW-1:0]   count_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [7:0]      mem_data [DEPTH];
   logic [7:0]      mem_pc   [DEPTH];

   logic            issue;
   logic            push;
   logic            pop;
   logic            halt_hit;
   logic            not_empty;

   // Occupancy counts the in-flight slot and ignores a same-cycle pop, so a
   // response always finds room without needing backpressure on memory.
   always_comb begin
      not_empty = (count_q != '0);
      issue     = !reset && (state_q == RUN) && !bus.redirect
                  && ((int'(count_q) + int'(inflight_q)) < DEPTH);
      push      = inflight_q && !bus.redirect && (state_q == RUN);
      pop       = not_empty && bus.inst_ready;
      halt_hit  = HALT_EN && push && (bus.imem_data == 8'h00);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         fetch_pc_q  <= RESET_PC;
         issued_pc_q <= 8'h00;
         inflight_q  <= 1'b0;
         halted_q    <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
      end else if (bus.redirect) begin
         state_q     <= RUN;
         fetch_pc_q  <= bus.redirect_pc;
         inflight_q  <= 1'b0;
         halted_q    <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            fetch_pc_q  <= fetch_pc_q + 8'd1;
            issued_pc_q <= fetch_pc_q;
         end
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
         if (halt_hit) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset: the head outputs are gated by occupancy.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_data[wr_ptr_q] <= bus.imem_data;
         mem_pc[wr_ptr_q]   <= issued_pc_q;
      end
   end

   assign bus.imem_rd_en = issue;
   assign bus.imem_addr  = fetch_pc_q;
   assign bus.inst_valid = not_empty;
   assign bus.inst_data  = not_empty ? mem_data[rd_ptr_q] : 8'h00;
   assign bus.inst_pc    = not_empty ? mem_pc[rd_ptr_q]   : 8'h00;
   assign bus.count      = count_q;
   assign bus.halted     = halted_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, every cycle
// checked against a queue-based model of the fetched instruction stream.
module tb_fetch_queue;
   localparam int         DEPTH    = 4;
   localparam logic [7:0] RESET_PC = 8'h00;
`ifdef FETCH_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] pc;
      logic [7:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_queue_if #(.DEPTH(DEPTH)) bus();
   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [256];
   always @(posedge clk)
      bus.imem_data <= bus.imem_rd_en ? mem[bus.imem_addr] : 8'($urandom);

   ent_t       exp_q [$];
   logic [7:0] popped [$];
   bit         m_pend;
   bit         m_halted;
   logic [7:0] m_ppc;
   logic [7:0] m_fpc;
   int         checks = 0;
   int         errors = 0;
   int         n_issue;
   int         lat;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: compare DUT outputs with the model at the falling edge, then
   // advance the model by the rules for what happens at the rising edge.
   task automatic tick();
      bit exp_issue;
      @(negedge clk);
      chk("inst_valid", 16'(bus.inst_valid), 16'(exp_q.size() != 0));
      chk("count", 16'(bus.count), 16'(exp_q.size()));
      chk("halted", 16'(bus.halted), 16'(m_halted));
      if (exp_q.size() != 0) begin
         chk("inst_pc", 16'(bus.inst_pc), 16'(exp_q[0].pc));
         chk("inst_data", 16'(bus.inst_data), 16'(exp_q[0].data));
      end else begin
         chk("inst_pc_empty", 16'(bus.inst_pc), 16'h0);
         chk("inst_data_empty", 16'(bus.inst_data), 16'h0);
      end
      exp_issue = !reset && !m_halted && !bus.redirect
                  && ((exp_q.size() + int'(m_pend)) < DEPTH);
      chk("imem_rd_en", 16'(bus.imem_rd_en), 16'(exp_issue));
      if (exp_issue) chk("imem_addr", 16'(bus.imem_addr), 16'(m_fpc));
      if (bus.imem_rd_en === 1'b1) n_issue++;

      if (reset) begin
         exp_q.delete();
         m_pend   = 1'b0;
         m_halted = 1'b0;
         m_fpc    = RESET_PC;
      end else begin
         if (exp_q.size() != 0 && bus.inst_ready) begin
            popped.push_back(bus.inst_pc);
            void'(exp_q.pop_front());
         end
         if (bus.redirect) begin
            exp_q.delete();
            m_pend   = 1'b0;
            m_halted = 1'b0;
            m_fpc    = bus.redirect_pc;
         end else begin
            if (m_pend && !m_halted) begin
               exp_q.push_back({m_ppc, mem[m_ppc]});
               if (HALT_EN && mem[m_ppc] == 8'h00) m_halted = 1'b1;
            end
            m_pend = exp_issue;
            if (exp_issue) begin
               m_ppc = m_fpc;
               m_fpc = m_fpc + 8'd1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 8'h00;
      bus.inst_ready  = 1'b1;
      for (int k = 0; k < 256; k++) mem[k] = 8'(k);
      if (HALT_EN) mem[0] = 8'hA5;
      m_pend = 1'b0; m_halted = 1'b0; m_fpc = RESET_PC; m_ppc = 8'h00;
      n_issue = 0;
      @(posedge clk);
      #1;
      tick();
      tick();

      // Reset release: first valid two cycles later, then one per cycle.
      reset = 1'b0;
      lat = 0;
      while (!bus.inst_valid && lat < 10) begin tick(); lat++; end
      chk("first_valid_latency", 16'(lat), 16'd2);
      popped.delete();
      repeat (10) tick();
      chk("stream_len", 16'(popped.size()), 16'd10);
      for (int i = 0; i < 10 && i < popped.size(); i++)
         chk("stream_pc", 16'(popped[i]), 16'(i));

      // Stalled consumer fills the queue with exactly DEPTH issues.
      bus.inst_ready = 1'b0;
      do_reset();
      n_issue = 0;
      repeat (8) tick();
      chk("full_issues", 16'(n_issue), 16'(DEPTH));
      chk("full_count", 16'(bus.count), 16'(DEPTH));
      chk("full_head_pc", 16'(bus.inst_pc), 16'h00);
      popped.delete();
      bus.inst_ready = 1'b1;
      repeat (5) tick();
      chk("drain_len_ok", 16'(popped.size() >= 4), 16'd1);
      for (int i = 0; i < 4 && i < popped.size(); i++)
         chk("drain_pc", 16'(popped[i]), 16'(i));

      // PC wrap through 8'hFF.
      bus.redirect = 1'b1; bus.redirect_pc = 8'hFE;
      tick();
      bus.redirect = 1'b0;
      popped.delete();
      repeat (8) tick();
      chk("wrap_len_ok", 16'(popped.size() >= 4), 16'd1);
      if (popped.size() >= 4) begin
         chk("wrap_pc0", 16'(popped[0]), 16'hFE);
         chk("wrap_pc1", 16'(popped[1]), 16'hFF);
         chk("wrap_pc2", 16'(popped[2]), 16'h00);
         chk("wrap_pc3", 16'(popped[3]), 16'h01);
      end

      // Redirect with three queued, one in flight, head popped on the same cycle.
      bus.inst_ready = 1'b0;
      do_reset();
      lat = 0;
      while (bus.count !== 3'd3 && lat < 20) begin tick(); lat++; end
      chk("redir_setup_count", 16'(bus.count), 16'd3);
      popped.delete();
      bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'h40;
      tick();
      bus.redirect = 1'b0;
      chk("redir_count", 16'(bus.count), 16'd0);
      chk("redir_head_pop", 16'(popped.size()), 16'd1);
      if (popped.size() > 0) chk("redir_head_pc", 16'(popped[0]), 16'h00);
      lat = 0;
      while (!bus.inst_valid && lat < 10) begin tick(); lat++; end
      chk("redir_latency", 16'(lat), 16'd2);
      chk("redir_first_pc", 16'(bus.inst_pc), 16'h40);
      repeat (4) tick();

      // Reset while three are held and one is in flight.
      bus.inst_ready = 1'b0;
      do_reset();
      lat = 0;
      while (bus.count !== 3'd3 && lat < 20) begin tick(); lat++; end
      reset = 1'b1;
      tick();
      chk("rst_count", 16'(bus.count), 16'd0);
      chk("rst_valid", 16'(bus.inst_valid), 16'd0);
      reset = 1'b0;
      bus.inst_ready = 1'b1;
      popped.delete();
      repeat (6) tick();
      chk("rst_first_pc_ok", 16'(popped.size() > 0), 16'd1);
      if (popped.size() > 0) chk("rst_first_pc", 16'(popped[0]), 16'(RESET_PC));

`ifdef FETCH_HALT_DETECT_EN
      // Halt word at address 5.
      reset = 1'b1;
      tick();
      for (int k = 0; k < 256; k++) mem[k] = 8'(k) | 8'h80;
      mem[5] = 8'h00;
      tick();
      reset = 1'b0;
      popped.delete();
      repeat (16) tick();
      chk("halt_flag", 16'(bus.halted), 16'd1);
      chk("halt_drained", 16'(popped.size()), 16'd6);
      if (popped.size() > 0) chk("halt_last_pc", 16'(popped[popped.size()-1]), 16'h05);
      n_issue = 0;
      repeat (8) tick();
      chk("halt_no_issue", 16'(n_issue), 16'd0);
      bus.redirect = 1'b1; bus.redirect_pc = 8'h20;
      tick();
      bus.redirect = 1'b0;
      chk("halt_cleared", 16'(bus.halted), 16'd0);
      popped.delete();
      repeat (6) tick();
      chk("halt_resume_ok", 16'(popped.size() > 0), 16'd1);
      if (popped.size() > 0) chk("halt_resume_pc", 16'(popped[0]), 16'h20);
`endif

      // Random traffic against the model.
      reset = 1'b1;
      tick();
      for (int k = 0; k < 256; k++)
         mem[k] = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 500; i++) begin
         bus.inst_ready  = ($urandom_range(0, 9) < 7);
         bus.redirect    = ($urandom_range(0, 19) == 0);
         bus.redirect_pc = 8'($urandom);
         reset           = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      bus.redirect = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch stage sitting directly upstream of the multi-cycle core's decode/execute sequencer. It issues sequential reads to the 8-bit instruction memory and buffers returned instruction bytes, each tagged with its PC, in a small FIFO. The core drains the FIFO over a valid/ready handshake and redirects fetch on taken jumps and branches.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16; sustained one-instruction-per-cycle throughput requires DEPTH >= 3
- RESET_PC, 8'h00, first fetch address after reset
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_rd_en  out  1  read request to instruction memory; 0 while reset is high
- imem_addr  out  8  read address, equal to internal fetch_pc
- imem_data  in  8  read data, valid exactly one cycle after the cycle imem_rd_en was high
- redirect  in  1  flush and restart fetch, one-cycle pulse
- redirect_pc  in  8  new fetch address, sampled when redirect=1
- inst_valid  out  1  head entry available
- inst_data  out  8  head instruction byte
- inst_pc  out  8  PC of head instruction
- inst_ready  in  1  consumer accepts head entry this cycle
- count  out  $clog2(DEPTH)+1  entries currently held
- halted  out  1  halt word captured, fetch stopped; tied 0 without FETCH_HALT_DETECT_EN

## Operation
- State machine: RUN, HALT. Reset enters RUN.
- Reset values: fetch_pc=RESET_PC, count=0, inst_valid=0, inst_data=0, inst_pc=0, halted=0, in-flight flag=0, state=RUN.
- Issue in RUN when (count + inflight) < DEPTH and redirect=0. imem_rd_en=1, imem_addr=fetch_pc. fetch_pc increments by 1 mod 256, so 8'hFF wraps to 8'h00. The in-flight flag is set, and the issued PC is held for tagging.
- Occupancy check is conservative. A pop in the same cycle does not free a slot until the next cycle.
- Response: in the cycle after issue, {imem_data, issued PC} is pushed at the tail unless the in-flight flag was killed.
- Pop: when inst_valid && inst_ready, the head advances. inst_valid = (count != 0). inst_data and inst_pc always reflect the head entry. Both are 0 when the FIFO is empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Redirect (highest priority):
  - A pop handshake in the redirect cycle completes normally.
  - All other entries are discarded, count becomes 0, and any in-flight response is killed and never pushed.
  - fetch_pc becomes redirect_pc, state becomes RUN, and halted is cleared.
  - imem_rd_en=0 in the redirect cycle.
- Reset mid-operation: all of the above state returns to reset values on the next edge. A pending memory response is dropped.

## Timing
- Request-to-valid latency: 2 cycles. Issue at cycle N, data captured at end of N+1, inst_valid=1 in N+2.
- After reset deasserts, the first imem_rd_en is in the first cycle with reset=0, addr=RESET_PC. The first inst_valid comes 2 cycles later.
- Redirect at cycle R: the queue is empty in R+1 and the first fetch of redirect_pc is issued in R+1. The first valid instruction at redirect_pc appears in R+3.
- Steady state with inst_ready=1 and DEPTH >= 3: one issue and one pop per cycle.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - A pushed entry with data 8'h00 (the core's halt encoding) moves state to HALT and sets halted=1 on the same edge.
  - In HALT, no issues occur. Any response for an address beyond the halt word is discarded.
  - Entries up to and including the halt word remain drainable.
  - Only redirect or reset leaves HALT.
- Not defined: 8'h00 is an ordinary instruction, state never leaves RUN, and halted is constant 0.

## Test plan
- Reset release, memory holds byte k at address k, inst_ready=1: inst_valid first high 2 cycles after reset low. Then one entry per cycle with inst_pc=0,1,2,... and inst_data=inst_pc.
- inst_ready=0, DEPTH=4: exactly 4 issues. count=4, imem_rd_en stays 0, and the head holds pc 0. Raising inst_ready drains 0..3 in order with no loss or duplication.
- fetch_pc starting at 8'hFE: inst_pc sequence is FE, FF, 00, 01.
- Redirect to 8'h40 with 3 entries queued, one in flight, and inst_ready=1 on the redirect cycle: the head entry is consumed. count=0 next cycle, the killed response never appears, and the next valid entry has inst_pc=8'h40, 2 cycles after reissue.
- With FETCH_HALT_DETECT_EN, 8'h00 at address 5: halted=1 once pc 5 is pushed. Entries 0..5 drain, no entry with pc 6 appears, and imem_rd_en stays 0. A later redirect clears halted and fetch resumes.
- Reset asserted while full and an issue is in flight: the next cycle shows count=0 and inst_valid=0, and no stale entry appears after release.
